pe_conv_sequencer: RTL and testbench

PE_CONV_SEQUENCER -- requirements
Module: pe_conv_sequencer

---
 rtl/pe_seq_pkg.sv | 15 +
 rtl/pe_seq_fifo.sv | 47 ++++
 rtl/pe_conv_sequencer.sv | 148 ++++++++++++++
 tb/tb_pe_conv_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types and PE control encodings for the PE convolution sequencer.
package pe_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOADW = 2'd1,
        S_LSB   = 2'd2,
        S_MSB   = 2'd3
    } seq_state_e;

    localparam logic [2:0] CTRL_STOREW = 3'b001;
    localparam logic [2:0] CTRL_LSB    = 3'b010;
    localparam logic [2:0] CTRL_CIRC   = 3'b100;

endpackage

// File: rtl/pe_seq_fifo.sv
// First-word-fall-through result FIFO, 16-bit entries, power-of-two depth.
// Push and pop in the same cycle are accepted at any occupancy, including full.
module pe_seq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [15:0]              push_data,
    input  logic                     pop,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign head    = empty ? 16'h0000 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pe_conv_sequencer.sv
// Sequences weight loads and two-byte operand issues into an 8-bit PE and
// collects {MSB, LSB} results in order. Optional counters: SEQ_PERF_EN.
module pe_conv_sequencer
    import pe_seq_pkg::*;
#(
    parameter int RES_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w_valid,
    input  logic [3:0]  w_code,
    output logic        w_ready,
    input  logic        op_valid,
    input  logic [7:0]  op_x,
    input  logic [15:0] op_y,
    output logic        op_ready,
    output logic [7:0]  pe_xorw,
    output logic [7:0]  pe_yin,
    output logic [2:0]  pe_ctrl,
    input  logic [7:0]  pe_y_out,
    output logic        res_valid,
    output logic [15:0] res_data,
    input  logic        res_ready,
    output logic        busy
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_e         state;
    logic [7:0]         y_hi;
    logic [RES_LAT+1:1] tags;
    logic [7:0]         lsb_hold;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [7:0]         in_flight;
    logic [7:0]         free_slots;
    logic               credit_ok;
    logic               accept;
    logic               push;
    logic               pop;

    // Each op owns exactly one tag bit from its LSB slot until its FIFO push.
    always_comb begin
        in_flight = '0;
        for (int i = 1; i <= RES_LAT + 1; i++) begin
            in_flight = in_flight + 8'(tags[i]);
        end
    end

    assign free_slots = 8'(FIFO_DEPTH) - 8'(fifo_count);
    assign credit_ok  = free_slots > in_flight;
    assign op_ready   = rst_n && ((state == S_IDLE) || (state == S_MSB)) && !w_valid && credit_ok;
    assign accept     = op_valid && op_ready;
    assign push       = tags[RES_LAT+1];
    assign res_valid  = !fifo_empty;
    assign pop        = res_valid && res_ready;
    assign busy       = (state != S_IDLE) || (|tags);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pe_ctrl <= CTRL_CIRC;
            pe_xorw <= '0;
            pe_yin  <= '0;
            w_ready <= 1'b0;
            y_hi    <= '0;
        end else begin
            w_ready <= 1'b0;
            case (state)
                S_IDLE, S_MSB: begin
                    if (accept) begin
                        state   <= S_LSB;
                        pe_ctrl <= CTRL_LSB;
                        pe_xorw <= op_x;
                        pe_yin  <= op_y[7:0];
                        y_hi    <= op_y[15:8];
                    end else if ((state == S_IDLE) && w_valid && (tags == '0)) begin
                        state   <= S_LOADW;
                        pe_ctrl <= CTRL_STOREW;
                        pe_xorw <= {4'b0000, w_code};
                        pe_yin  <= '0;
                        w_ready <= 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        pe_ctrl <= CTRL_CIRC;
                        pe_xorw <= '0;
                        pe_yin  <= '0;
                    end
                end
                S_LSB: begin
                    // pe_xorw keeps the multiplicand for the circulate byte.
                    state   <= S_MSB;
                    pe_ctrl <= CTRL_CIRC;
                    pe_yin  <= y_hi;
                end
                default: begin
                    state   <= S_IDLE;
                    pe_ctrl <= CTRL_CIRC;
                    pe_xorw <= '0;
                    pe_yin  <= '0;
                end
            endcase
        end
    end

    // RES_LAT must be at least 1 so the LSB capture precedes the MSB push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tags     <= '0;
            lsb_hold <= '0;
        end else begin
            tags <= {tags[RES_LAT:1], (state == S_LSB)};
            if (tags[RES_LAT]) lsb_hold <= pe_y_out;
        end
    end

    pe_seq_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({pe_y_out, lsb_hold}),
        .pop       (pop),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (res_data)
    );

`ifdef SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept) perf_ops <= perf_ops + 32'd1;
            if (op_valid && !op_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Directed bench for pe_conv_sequencer with a behavioural 8-bit PE attached.
// Inputs change on the falling edge; outputs are sampled on or just after it.
module tb_pe_conv_sequencer;
    import pe_seq_pkg::*;

    localparam int RES_LAT    = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        w_valid   = 1'b0;
    logic [3:0]  w_code    = 4'h0;
    logic        w_ready;
    logic        op_valid  = 1'b0;
    logic [7:0]  op_x      = 8'h00;
    logic [15:0] op_y      = 16'h0000;
    logic        op_ready;
    logic [7:0]  pe_xorw;
    logic [7:0]  pe_yin;
    logic [2:0]  pe_ctrl;
    logic [7:0]  pe_y_out;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready = 1'b1;
    logic        busy;
`ifdef SEQ_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_res = 0;
    logic [15:0] exp_q[$];
    logic [3:0]  bench_w = 4'h0;

    logic [7:0]  b2b_x [6] = '{8'h01, 8'hFF, 8'h80, 8'h7F, 8'h3C, 8'hA5};
    logic [15:0] b2b_y [6] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h8000, 16'h00FF, 16'hC3C3};
    logic [7:0]  bp_x  [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [15:0] bp_y  [8] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000,
                               16'h5000, 16'h6000, 16'h7000, 16'h8000};

    always #5 clk = ~clk;

    pe_conv_sequencer #(
        .RES_LAT    (RES_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_valid   (w_valid),
        .w_code    (w_code),
        .w_ready   (w_ready),
        .op_valid  (op_valid),
        .op_x      (op_x),
        .op_y      (op_y),
        .op_ready  (op_ready),
        .pe_xorw   (pe_xorw),
        .pe_yin    (pe_yin),
        .pe_ctrl   (pe_ctrl),
        .pe_y_out  (pe_y_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef SEQ_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    // PE: stores {sign, shift}; LSB slot adds +/-(x<<shift) to yIn byte and keeps
    // the upper partial; circulate adds that partial to the yIn byte.
    logic [3:0] pe_w     = 4'h0;
    logic [7:0] pe_carry = 8'h00;
    logic [7:0] pe_pipe [RES_LAT] = '{default: 8'h00};
    assign pe_y_out = pe_pipe[RES_LAT-1];

    always @(posedge clk) begin : pe_model
        logic [15:0] prod;
        logic [15:0] lo_sum;
        logic [7:0]  out_b;
        prod = {8'h00, pe_xorw} << pe_w[2:0];
        if (pe_w[3]) prod = -prod;
        lo_sum = {8'h00, pe_yin} + prod;
        case (pe_ctrl)
            CTRL_STOREW: begin
                pe_w  <= pe_xorw[3:0];
                out_b = 8'h00;
            end
            CTRL_LSB: begin
                pe_carry <= lo_sum[15:8];
                out_b = lo_sum[7:0];
            end
            default: out_b = pe_yin + pe_carry;
        endcase
        pe_pipe[0] <= out_b;
        for (int k = 1; k < RES_LAT; k++) pe_pipe[k] <= pe_pipe[k-1];
    end

    function automatic logic [15:0] ref_result(input logic [3:0] w, input logic [7:0] x,
                                               input logic [15:0] y);
        logic [15:0] mag;
        mag = 16'(x) * (16'd1 << w[2:0]);
        return w[3] ? (y - mag) : (y + mag);
    endfunction

    // Scoreboard: every consumed result must match the oldest expected value.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && res_valid && res_ready) begin
            n_vec++;
            n_res++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h, no result expected", res_data);
            end else begin
                logic [15:0] sb_exp;
                sb_exp = exp_q.pop_front();
                if (res_data !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_data: got %h want %h", res_data, sb_exp);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0 || res_valid !== 1'b0) && c < 200) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (exp_q.size() != 0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: pending=%0d busy=%b res_valid=%b want 0/0/0",
                     name, exp_q.size(), busy, res_valid);
            exp_q.delete();
        end
    endtask

    task automatic send_op(input logic [7:0] x, input logic [15:0] y, input string name);
        int c = 0;
        op_valid = 1'b1;
        op_x     = x;
        op_y     = y;
        #1;
        while (op_ready !== 1'b1 && c < 50) begin
            @(negedge clk);
            #1;
            c++;
        end
        n_vec++;
        if (op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_accept: op_ready=%b want 1 within 50 cycles", name, op_ready);
        end else begin
            exp_q.push_back(ref_result(bench_w, x, y));
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        op_valid  = 1'b1;
        op_x      = 8'h12;
        op_y      = 16'h0100;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (pe_ctrl !== CTRL_CIRC || op_ready !== 1'b0 || res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: ctrl=%b op_ready=%b res_valid=%b want 100/0/0",
                         pe_ctrl, op_ready, res_valid);
            end
        end
        n_vec++;
        if ({w_ready, busy, pe_xorw, pe_yin, res_data} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_outs: w_ready=%b busy=%b xorw=%h yin=%h res=%h want all 0",
                     w_ready, busy, pe_xorw, pe_yin, res_data);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL first_accept: op_ready=%b want 1", op_ready);
        end else begin
            exp_q.push_back(16'h0112);
        end
        @(negedge clk);
        op_valid = 1'b0;
        wait_drain("reset_first");
    endtask

    task automatic test_weight_then_op();
        int c = 0;
        w_valid = 1'b1;
        w_code  = 4'b1011;
        @(negedge clk);
        while (w_ready !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (c != 0 || w_ready !== 1'b1 || pe_ctrl !== CTRL_STOREW || pe_xorw !== 8'h0B || pe_yin !== 8'h00) begin
            n_err++;
            $display("FAIL load_w: wait=%0d w_ready=%b ctrl=%b xorw=%h yin=%h want 0/1/001/0b/00",
                     c, w_ready, pe_ctrl, pe_xorw, pe_yin);
        end
        w_valid = 1'b0;
        bench_w = 4'b1011;
        @(negedge clk);
        op_valid = 1'b1;
        op_x     = 8'hB5;
        op_y     = 16'h5DCD;
        #1;
        n_vec++;
        if (op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wop_ready: op_ready=%b want 1", op_ready);
        end
        exp_q.push_back(16'h5825);
        @(negedge clk);
        op_valid = 1'b0;
        n_vec++;
        if (pe_ctrl !== CTRL_LSB || pe_xorw !== 8'hB5 || pe_yin !== 8'hCD) begin
            n_err++;
            $display("FAIL wop_lsb: ctrl=%b xorw=%h yin=%h want 010/b5/cd", pe_ctrl, pe_xorw, pe_yin);
        end
        @(negedge clk);
        n_vec++;
        if (pe_ctrl !== CTRL_CIRC || pe_xorw !== 8'hB5 || pe_yin !== 8'h5D) begin
            n_err++;
            $display("FAIL wop_msb: ctrl=%b xorw=%h yin=%h want 100/b5/5d", pe_ctrl, pe_xorw, pe_yin);
        end
        repeat (RES_LAT) @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wop_early: res_valid=%b want 0 at LSB+%0d", res_valid, RES_LAT + 1);
        end
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 16'h5825) begin
            n_err++;
            $display("FAIL wop_result: valid=%b data=%h want 1/5825", res_valid, res_data);
        end
        wait_drain("wop");
    endtask

    task automatic test_back_to_back();
        int start = n_res;
        op_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op_x = b2b_x[i];
            op_y = b2b_y[i];
            #1;
            n_vec++;
            if (op_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: op_ready=%b want 1", i, op_ready);
            end
            exp_q.push_back(ref_result(bench_w, b2b_x[i], b2b_y[i]));
            @(negedge clk);
            n_vec++;
            if (pe_ctrl !== CTRL_LSB || pe_xorw !== b2b_x[i]) begin
                n_err++;
                $display("FAIL b2b_lsb[%0d]: ctrl=%b xorw=%h want 010/%h", i, pe_ctrl, pe_xorw, b2b_x[i]);
            end
            @(negedge clk);
            n_vec++;
            if (pe_ctrl !== CTRL_CIRC || pe_yin !== b2b_y[i][15:8]) begin
                n_err++;
                $display("FAIL b2b_msb[%0d]: ctrl=%b yin=%h want 100/%h", i, pe_ctrl, pe_yin, b2b_y[i][15:8]);
            end
        end
        op_valid = 1'b0;
        wait_drain("b2b");
        n_vec++;
        if (n_res - start != 6) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results want 6", n_res - start);
        end
    endtask

    task automatic test_backpressure();
        int idx   = 0;
        int c     = 0;
        int start = n_res;
        res_ready = 1'b0;
        op_valid  = 1'b1;
        op_x      = bp_x[0];
        op_y      = bp_y[0];
        for (int k = 0; k < 40; k++) begin
            #1;
            if (op_ready === 1'b1 && idx < 8) begin
                exp_q.push_back(ref_result(bench_w, bp_x[idx], bp_y[idx]));
                idx++;
            end
            @(negedge clk);
            if (idx < 8) begin
                op_x = bp_x[idx];
                op_y = bp_y[idx];
            end
        end
        n_vec++;
        if (idx != FIFO_DEPTH) begin
            n_err++;
            $display("FAIL bp_accepts: got %0d accepted want %0d", idx, FIFO_DEPTH);
        end
        n_vec++;
        if (op_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL bp_hold: op_ready=%b res_valid=%b head=%h want 0/1/%h",
                     op_ready, res_valid, res_data, exp_q[0]);
        end
        res_ready = 1'b1;
        while (idx < 8 && c < 100) begin
            #1;
            if (op_ready === 1'b1) begin
                exp_q.push_back(ref_result(bench_w, bp_x[idx], bp_y[idx]));
                idx++;
            end
            @(negedge clk);
            c++;
            if (idx < 8) begin
                op_x = bp_x[idx];
                op_y = bp_y[idx];
            end
        end
        op_valid = 1'b0;
        wait_drain("bp");
        n_vec++;
        if (n_res - start != 8) begin
            n_err++;
            $display("FAIL bp_count: got %0d results want 8", n_res - start);
        end
    endtask

    task automatic test_priority();
        int c = 0;
        send_op(8'h40, 16'h0400, "prio_a");
        w_valid  = 1'b1;
        w_code   = 4'b0010;
        op_valid = 1'b1;
        op_x     = 8'h09;
        op_y     = 16'h1111;
        while (w_ready !== 1'b1 && c < 20) begin
            #1;
            n_vec++;
            if (op_ready !== 1'b0 || w_ready !== 1'b0) begin
                n_err++;
                $display("FAIL prio_block[%0d]: op_ready=%b w_ready=%b want 0/0", c, op_ready, w_ready);
            end
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (c != RES_LAT + 3 || w_ready !== 1'b1 || pe_ctrl !== CTRL_STOREW || pe_xorw !== 8'h02) begin
            n_err++;
            $display("FAIL prio_loadw: wait=%0d w_ready=%b ctrl=%b xorw=%h want %0d/1/001/02",
                     c, w_ready, pe_ctrl, pe_xorw, RES_LAT + 3);
        end
        w_valid = 1'b0;
        bench_w = 4'b0010;
        @(negedge clk);
        #1;
        n_vec++;
        if (op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL prio_op: op_ready=%b want 1 after LOADW", op_ready);
        end
        exp_q.push_back(16'h1135);
        @(negedge clk);
        op_valid = 1'b0;
        wait_drain("prio");
    endtask

    task automatic test_midop_reset();
        int start;
        send_op(8'hEE, 16'hABCD, "mid_c");
        @(negedge clk);
        n_vec++;
        if (pe_ctrl !== CTRL_CIRC || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_msb: ctrl=%b busy=%b want 100/1", pe_ctrl, busy);
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || pe_ctrl !== CTRL_CIRC) begin
            n_err++;
            $display("FAIL mid_rst: res_valid=%b busy=%b ctrl=%b want 0/0/100", res_valid, busy, pe_ctrl);
        end
        for (int k = 0; k < RES_LAT + 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_stale[%0d]: res_valid=%b want 0", k, res_valid);
            end
        end
        start = n_res;
        send_op(8'h03, 16'h0020, "mid_d");
        wait_drain("mid");
        n_vec++;
        if (n_res - start != 1) begin
            n_err++;
            $display("FAIL mid_count: got %0d results want 1", n_res - start);
        end
    endtask

    initial begin
        test_reset();
        test_weight_then_op();
        test_back_to_back();
        test_backpressure();
        test_priority();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
